// File: rtl/count_direction_decoder_if.sv
// Sample/result bundle between an observed counter stream and the direction decoder.
// master drives samples and reads results; slave is the decoder side.
interface count_direction_decoder_if #(
    parameter int unsigned N = 2
);
    logic         valid_in;
    logic [N-1:0] count_in;
    logic         up_or_down;
    logic         locked;
    logic         dir_change;
    logic         step_err;
    logic         hold;
    logic [15:0]  step_cnt;

    modport master (
        output valid_in, count_in,
        input  up_or_down, locked, dir_change, step_err, hold, step_cnt
    );

    modport slave (
        input  valid_in, count_in,
        output up_or_down, locked, dir_change, step_err, hold, step_cnt
    );
endinterface

// File: rtl/count_direction_decoder.sv
// Recovers counting direction and lock status from an observed N-bit count stream,
// classifying each sample as +1, -1, hold or illegal jump (mod 2^N).
module count_direction_decoder #(
    parameter int unsigned N    = 2,
    parameter int unsigned LOCK = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    count_direction_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        SEEK   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [3:0]   LOCK_R = 4'(LOCK);
    localparam logic [N-1:0] ONE    = {{(N-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [N-1:0] prev_q, prev_d;
    logic [3:0]   run_q, run_d;
    logic         up_q, up_d;
    logic         locked_q, locked_d;
    logic         dir_change_q, dir_change_d;
    logic         step_err_q, step_err_d;
    logic         hold_q, hold_d;
    logic [15:0]  step_cnt_q, step_cnt_d;

    logic [N-1:0] diff;
    logic         is_up, is_dn, is_hold;
    logic [3:0]   run_inc;

    // Modular difference: wrap (max -> 0) is an ordinary +1 step.
    assign diff    = bus.count_in - prev_q;
    assign is_up   = (diff == ONE);
    assign is_dn   = (diff == '1);
    assign is_hold = (diff == '0);
    assign run_inc = (run_q >= LOCK_R) ? LOCK_R : run_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        up_d         = up_q;
        locked_d     = locked_q;
        dir_change_d = 1'b0;
        step_err_d   = 1'b0;
        hold_d       = hold_q;
        step_cnt_d   = step_cnt_q;

        if (bus.valid_in) begin
            prev_d = bus.count_in;
            if (state_q == ACQ) begin
                state_d = SEEK;
                run_d   = '0;
            end else if (is_hold) begin
                hold_d = 1'b1;
            end else if (is_up || is_dn) begin
                hold_d     = 1'b0;
                step_cnt_d = step_cnt_q + 16'd1;
                if (state_q == LOCKED) begin
                    if (is_up != up_q) begin
                        up_d         = is_up;
                        dir_change_d = 1'b1;
                        run_d        = 4'd1;
                        // With LOCK=1 a single reversed step already re-confirms the lock.
                        if (LOCK != 1) begin
                            state_d  = SEEK;
                            locked_d = 1'b0;
                        end
                    end
                end else begin
                    if ((run_q != '0) && (is_up == up_q)) begin
                        run_d = run_inc;
                    end else begin
                        run_d = 4'd1;
                        up_d  = is_up;
                    end
                    if (run_d >= LOCK_R) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
            end else begin
                step_err_d = 1'b1;
                hold_d     = 1'b0;
                run_d      = '0;
                locked_d   = 1'b0;
                state_d    = SEEK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACQ;
            prev_q       <= '0;
            run_q        <= '0;
            up_q         <= 1'b1;
            locked_q     <= 1'b0;
            dir_change_q <= 1'b0;
            step_err_q   <= 1'b0;
            hold_q       <= 1'b0;
            step_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            up_q         <= up_d;
            locked_q     <= locked_d;
            dir_change_q <= dir_change_d;
            step_err_q   <= step_err_d;
            hold_q       <= hold_d;
            step_cnt_q   <= step_cnt_d;
        end
    end

    assign bus.up_or_down = up_q;
    assign bus.locked     = locked_q;
    assign bus.dir_change = dir_change_q;
    assign bus.step_err   = step_err_q;
    assign bus.hold       = hold_q;
    assign bus.step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// Directed bench for count_direction_decoder: a reference model queues expected
// results per driven cycle; each registered result is popped and compared.
module tb_count_direction_decoder;

    localparam int unsigned N    = 2;
    localparam int unsigned LOCK = 2;

    typedef struct packed {
        logic        ud;
        logic        lk;
        logic        dc;
        logic        se;
        logic        ho;
        logic [15:0] sc;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    count_direction_decoder_if #(.N(N)) bus ();

    count_direction_decoder #(.N(N), .LOCK(LOCK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    // reference model state: 0 = acquire, 1 = seek, 2 = locked
    int   m_state;
    int   m_prev;
    int   m_run;
    res_t m;

    function automatic res_t observed();
        res_t r;
        r = {bus.up_or_down, bus.locked, bus.dir_change, bus.step_err, bus.hold, bus.step_cnt};
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_prev  = 0;
        m_run   = 0;
        m       = '0;
        m.ud    = 1'b1;
    endtask

    task automatic model_step(input logic v, input int c);
        int  d;
        bit  up;
        m.dc = 1'b0;
        m.se = 1'b0;
        if (v) begin
            d = (c - m_prev) & ((1 << N) - 1);
            if (m_state == 0) begin
                m_state = 1;
                m_run   = 0;
            end else if (d == 0) begin
                m.ho = 1'b1;
            end else if (d == 1 || d == (1 << N) - 1) begin
                up   = (d == 1);
                m.ho = 1'b0;
                m.sc = m.sc + 16'd1;
                if (m_state == 2) begin
                    if (up != m.ud) begin
                        m.ud  = up;
                        m.dc  = 1'b1;
                        m_run = 1;
                        if (LOCK > 1) begin
                            m_state = 1;
                            m.lk    = 1'b0;
                        end
                    end
                end else begin
                    if (m_run > 0 && up == m.ud) m_run = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
                    else begin
                        m_run = 1;
                        m.ud  = up;
                    end
                    if (m_run >= LOCK) begin
                        m_state = 2;
                        m.lk    = 1'b1;
                    end
                end
            end else begin
                m.se    = 1'b1;
                m.ho    = 1'b0;
                m.lk    = 1'b0;
                m_run   = 0;
                m_state = 1;
            end
            m_prev = c;
        end
        sb.push_back(m);
    endtask

    task automatic cycle(input logic v, input int c, input string tag);
        res_t exp_r;
        res_t got_r;
        bus.valid_in = v;
        bus.count_in = c[N-1:0];
        model_step(v, c);
        @(posedge clk);
        #1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            exp_r = sb.pop_front();
            got_r = observed();
            assert (got_r === exp_r) else begin
                bad++;
                $error("FAIL %s v=%0b c=%0d observed=%h expected=%h", tag, v, c, got_r, exp_r);
            end
        end
    endtask

    task automatic dchk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        assert (got === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
        end
    endtask

    // Asserts reset between edges, checks it took effect without a clock, then releases.
    task automatic do_reset(input string tag);
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        #1;
        dchk(tag, 32'(observed()), 32'({1'b1, 4'b0000, 16'h0000}));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.count_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        dchk("reset_vals", 32'(observed()), 32'({1'b1, 4'b0000, 16'h0000}));
        rst_n = 1'b1;

        // up stream with wrap
        cycle(1, 0, "up0");
        cycle(1, 1, "up1");
        dchk("up_not_locked", 32'(bus.locked), 32'd0);
        cycle(1, 2, "up2");
        dchk("up_locked", 32'(bus.locked), 32'd1);
        cycle(1, 3, "up3");
        cycle(1, 0, "up_wrap");
        cycle(1, 1, "up5");
        dchk("up_cnt", 32'(bus.step_cnt), 32'd5);
        dchk("up_dir", 32'(bus.up_or_down), 32'd1);

        // async reset mid-stream, then re-baseline
        do_reset("rst_mid_async");
        cycle(1, 2, "rebase");
        dchk("rebase_cnt", 32'(bus.step_cnt), 32'd0);
        cycle(1, 3, "rebase_step");
        dchk("rebase_step_cnt", 32'(bus.step_cnt), 32'd1);

        // reversal
        do_reset("rst_rev");
        cycle(1, 0, "rv0");
        cycle(1, 1, "rv1");
        cycle(1, 2, "rv2");
        cycle(1, 1, "rv_flip");
        dchk("rv_dc", 32'(bus.dir_change), 32'd1);
        dchk("rv_unlock", 32'(bus.locked), 32'd0);
        cycle(1, 0, "rv_relock");
        dchk("rv_dc_clear", 32'(bus.dir_change), 32'd0);
        dchk("rv_relocked", 32'(bus.locked), 32'd1);
        cycle(1, 3, "rv_wrap_dn");
        dchk("rv_dir", 32'(bus.up_or_down), 32'd0);

        // holds with idle gaps, entered already locked
        do_reset("rst_hold");
        cycle(1, 0, "hd_base");
        for (int i = 0; i < 5; i++) begin
            int vals[5] = '{1, 2, 2, 2, 3};
            cycle(1, vals[i], $sformatf("hd_s%0d", i));
            if (i == 3) dchk("hd_hold_flag", 32'(bus.hold), 32'd1);
            for (int g = 0; g < 3; g++) cycle(0, 0, "hd_gap");
            if (i >= 1) dchk("hd_locked", 32'(bus.locked), 32'd1);
        end
        dchk("hd_hold_cleared", 32'(bus.hold), 32'd0);
        dchk("hd_cnt", 32'(bus.step_cnt), 32'd3);

        // illegal jump while locked
        do_reset("rst_jump");
        cycle(1, 0, "jp0");
        cycle(1, 1, "jp1");
        cycle(1, 2, "jp2");
        cycle(1, 0, "jp_jump");
        dchk("jp_err", 32'(bus.step_err), 32'd1);
        dchk("jp_unlock", 32'(bus.locked), 32'd0);
        dchk("jp_dir_kept", 32'(bus.up_or_down), 32'd1);
        cycle(1, 1, "jp_after1");
        dchk("jp_err_pulse", 32'(bus.step_err), 32'd0);
        cycle(1, 2, "jp_relock");
        dchk("jp_relocked", 32'(bus.locked), 32'd1);
        dchk("jp_cnt", 32'(bus.step_cnt), 32'd4);

        // down stream from reset
        do_reset("rst_down");
        cycle(1, 3, "dn3");
        cycle(1, 2, "dn2");
        dchk("dn_dir_early", 32'(bus.up_or_down), 32'd0);
        cycle(1, 1, "dn1");
        dchk("dn_locked", 32'(bus.locked), 32'd1);
        cycle(1, 0, "dn0");
        cycle(1, 3, "dn_wrap");
        dchk("dn_cnt", 32'(bus.step_cnt), 32'd4);

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
